// File: rtl/mem_copy_master.sv
// Memory-to-memory word copier driving a single-port RAM (sync write, comb read); 2 cycles per word,
// done one cycle after the last write. No flow control: start is accepted only in IDLE, abort stops the copy.
module mem_copy_master #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aborted,
    output logic [ADDR_W-1:0] words_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [ADDR_W-1:0] wdone_q, wdone_d;
    logic              err_q, err_d;
    logic              abt_q, abt_d;

    // One extra bit so src+len cannot wrap and sneak under the depth limit
    logic [ADDR_W:0] src_end;
    logic [ADDR_W:0] dst_end;
    logic            range_bad;

    assign src_end   = {1'b0, src_addr} + {1'b0, len};
    assign dst_end   = {1'b0, dst_addr} + {1'b0, len};
    assign range_bad = (src_end > DEPTH) || (dst_end > DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            rbuf_q  <= '0;
            wdone_q <= '0;
            err_q   <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            rbuf_q  <= rbuf_d;
            wdone_q <= wdone_d;
            err_q   <= err_d;
            abt_q   <= abt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        rbuf_d  = rbuf_q;
        wdone_d = wdone_q;
        err_d   = err_q;
        abt_d   = abt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = len;
                    wdone_d = '0;
                    err_d   = 1'b0;
                    abt_d   = 1'b0;
                    if (range_bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rbuf_d  = mem_rdata;
                    src_d   = src_q + ADDR_W'(1);
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // The write lands on this edge regardless of abort, so it is always counted
                dst_d   = dst_q + ADDR_W'(1);
                rem_d   = rem_q - ADDR_W'(1);
                wdone_d = wdone_q + ADDR_W'(1);
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = S_DONE;
                end else if (rem_q == ADDR_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        case (state_q)
            S_RD:    mem_addr = src_q;
            S_WR:    mem_addr = dst_q;
            default: mem_addr = '0;
        endcase
    end

    assign mem_we     = (state_q == S_WR);
    assign mem_wdata  = rbuf_q;
    assign busy       = (state_q == S_RD) || (state_q == S_WR);
    assign done       = (state_q == S_DONE);
    assign error      = err_q;
    assign aborted    = abt_q;
    assign words_done = wdone_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: behavioural RAM beside the DUT plus a plain-array reference copy.
module tb_mem_copy_master;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] src_addr, dst_addr, len;
    logic        abort;
    logic        busy, done, error, aborted;
    logic [15:0] words_done, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [15:0] mem    [256];
    logic [15:0] init_m [256];
    logic [15:0] refm   [256];
    logic        load_req;

    int errors = 0;
    int checks = 0;

    mem_copy_master #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .aborted    (aborted),
        .words_done (words_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_req) mem <= init_m;
        else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[7:0]];

    task automatic load_random;
        for (int i = 0; i < 256; i++) init_m[i] = 16'($urandom);
    endtask

    task automatic commit_load;
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        for (int i = 0; i < 256; i++) refm[i] = init_m[i];
    endtask

    // Reference: word-by-word ascending copy on the model array
    task automatic ref_copy(input int s, input int d, input int n);
        for (int i = 0; i < n; i++) refm[d+i] = refm[s+i];
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refm[i]) n++;
        return n;
    endfunction

    task automatic check_mem(input string name);
        int n;
        n = mem_diff();
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL %s: %0d memory words differ, required 0", name, n);
        end
    endtask

    task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the start edge until done; abort_at>0 pulses abort in that cycle
    task automatic wait_done(output int cyc, output int we_cnt, input int abort_at);
        bit fin = 0;
        cyc = 0; we_cnt = 0;
        while (!fin) begin
            @(negedge clk);
            abort = 1'b0;
            cyc++;
            if (mem_we === 1'b1) we_cnt++;
            if (done === 1'b1) fin = 1;
            else if (cyc == abort_at) abort = 1'b1;
            else if (cyc > 2000) begin
                checks++; errors++;
                $display("FAIL timeout: no done after %0d cycles, required done", cyc);
                fin = 1;
            end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_req = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({busy, done, error, aborted, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/done/err/abt/we=%b required 00000",
                     {busy, done, error, aborted, mem_we});
        end
        checks++;
        if (words_done !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_buses: wd=%h addr=%h wdata=%h required 0", words_done, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_copy;
        int cyc, we;
        load_random();
        init_m[16] = 16'hA1; init_m[17] = 16'hB2; init_m[18] = 16'hC3; init_m[19] = 16'hD4;
        commit_load();
        ref_copy(16, 128, 4);
        issue(16'h10, 16'h80, 16'd4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL copy_busy: busy=%b required 1", busy); end
        wait_done(cyc, we, 0);
        checks++;
        if (cyc !== 9) begin errors++; $display("FAIL copy_cycle: done in cycle %0d required 9", cyc); end
        checks++;
        if (words_done !== 16'd4 || error !== 1'b0 || we !== 4) begin
            errors++;
            $display("FAIL copy_status: wd=%0d err=%b writes=%0d required 4,0,4", words_done, error, we);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL copy_pulse: done=%b busy=%b one cycle later, required 0,0", done, busy);
        end
        checks++;
        if (mem[128] !== 16'hA1 || mem[131] !== 16'hD4) begin
            errors++;
            $display("FAIL copy_data: mem[80]=%h mem[83]=%h required a1,d4", mem[128], mem[131]);
        end
        check_mem("copy_mem");
    endtask

    task automatic test_len0;
        int cyc, we;
        issue(16'h20, 16'h30, 16'd0);
        wait_done(cyc, we, 0);
        checks++;
        if (cyc !== 1 || we !== 0 || words_done !== 16'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL len0: cyc=%0d writes=%0d wd=%0d err=%b required 1,0,0,0", cyc, we, words_done, error);
        end
    endtask

    task automatic test_range;
        int cyc, we;
        issue(16'hFE, 16'h40, 16'd3);
        wait_done(cyc, we, 0);
        checks++;
        if (error !== 1'b1 || cyc !== 1 || we !== 0) begin
            errors++;
            $display("FAIL range_src: err=%b cyc=%0d writes=%0d required 1,1,0", error, cyc, we);
        end
        issue(16'h40, 16'hFF, 16'd2);
        wait_done(cyc, we, 0);
        checks++;
        if (error !== 1'b1 || we !== 0) begin
            errors++;
            $display("FAIL range_dst: err=%b writes=%0d required 1,0", error, we);
        end
        check_mem("range_nowrite");
        issue(16'hFD, 16'h50, 16'd3);
        ref_copy(253, 80, 3);
        wait_done(cyc, we, 0);
        checks++;
        if (error !== 1'b0 || cyc !== 7 || words_done !== 16'd3) begin
            errors++;
            $display("FAIL range_edge: err=%b cyc=%0d wd=%0d required 0,7,3", error, cyc, words_done);
        end
        check_mem("range_edge_mem");
    endtask

    task automatic test_abort;
        int cyc, we, k, s, d, expw;
        load_random();
        commit_load();
        // Third WR cycle is cycle 6
        issue(16'h08, 16'hA0, 16'd8);
        ref_copy(8, 160, 3);
        wait_done(cyc, we, 6);
        checks++;
        if (words_done !== 16'd3 || aborted !== 1'b1 || cyc !== 7) begin
            errors++;
            $display("FAIL abort_wr: wd=%0d abt=%b cyc=%0d required 3,1,7", words_done, aborted, cyc);
        end
        check_mem("abort_wr_mem");
        for (int it = 0; it < 4; it++) begin
            s = $urandom_range(0, 100);
            d = $urandom_range(120, 200);
            k = $urandom_range(1, 16);
            expw = k / 2;
            issue(16'(s), 16'(d), 16'd8);
            ref_copy(s, d, expw);
            wait_done(cyc, we, k);
            checks++;
            if (words_done !== 16'(expw) || aborted !== 1'b1 || cyc !== k + 1) begin
                errors++;
                $display("FAIL abort_rand: k=%0d wd=%0d abt=%b cyc=%0d required %0d,1,%0d",
                         k, words_done, aborted, cyc, expw, k + 1);
            end
            check_mem("abort_rand_mem");
        end
    endtask

    task automatic test_reset_mid;
        load_random();
        commit_load();
        issue(16'h00, 16'h60, 16'd5);
        ref_copy(0, 96, 1);
        repeat (4) @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre: we=%b required 1", mem_we); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || words_done !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_async: we=%b busy=%b wd=%0d required 0,0,0", mem_we, busy, words_done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_mem("rstmid_mem");
    endtask

    task automatic test_back_to_back;
        int cyc, we;
        load_random();
        commit_load();
        issue(16'h20, 16'h90, 16'd4);
        ref_copy(32, 144, 4);
        repeat (3) @(negedge clk);
        src_addr = 16'h70; dst_addr = 16'hC0; len = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, we, 0);
        checks++;
        if (words_done !== 16'd4 || cyc !== 5) begin
            errors++;
            $display("FAIL busy_start: wd=%0d cyc=%0d required 4,5", words_done, cyc);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || words_done !== 16'd4) begin
            errors++;
            $display("FAIL done_start: busy=%b wd=%0d required 0,4", busy, words_done);
        end
        check_mem("busy_start_mem");
    endtask

    task automatic test_overlap;
        int cyc, we;
        load_random();
        init_m[0] = 16'd1; init_m[1] = 16'd2; init_m[2] = 16'd3; init_m[3] = 16'd4;
        commit_load();
        ref_copy(0, 1, 3);
        issue(16'd0, 16'd1, 16'd3);
        wait_done(cyc, we, 0);
        checks++;
        if (mem[0] !== 16'd1 || mem[1] !== 16'd1 || mem[2] !== 16'd1 || mem[3] !== 16'd1) begin
            errors++;
            $display("FAIL overlap: mem[0..3]=%0d,%0d,%0d,%0d required 1,1,1,1", mem[0], mem[1], mem[2], mem[3]);
        end
        check_mem("overlap_mem");
    endtask

    task automatic test_random;
        int cyc, we, s, d, n, exp_cyc;
        bit exp_err;
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(0, 255);
            d = $urandom_range(0, 255);
            n = $urandom_range(0, 12);
            exp_err = (s + n > 256) || (d + n > 256);
            exp_cyc = (exp_err || n == 0) ? 1 : 2 * n + 1;
            if (!exp_err) ref_copy(s, d, n);
            issue(16'(s), 16'(d), 16'(n));
            wait_done(cyc, we, 0);
            checks++;
            if (error !== exp_err || cyc !== exp_cyc || words_done !== (exp_err ? 16'd0 : 16'(n))) begin
                errors++;
                $display("FAIL rand: s=%0d d=%0d n=%0d err=%b cyc=%0d wd=%0d required %b,%0d",
                         s, d, n, error, cyc, words_done, exp_err, exp_cyc);
            end
            check_mem("rand_mem");
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_len0();
        test_range();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_overlap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
